// File: rtl/wb_arbiter_rr_2.sv
// Two-master Wishbone round-robin arbiter in front of one shared slave.
// The grant is held for the owner's whole CYC; one dead cycle separates owners.
module wb_arbiter_rr_2 #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned SELECT_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    output logic                    wbm0_ack_o,
    input  logic                    wbm0_cyc_i,

    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    output logic                    wbm1_ack_o,
    input  logic                    wbm1_cyc_i,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    input  logic                    wbs_ack_i,
    output logic                    wbs_cyc_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    state_e state_q;
    logic   grant_sel_q;
    logic   last_sel_q;
    logic   grant_sel_d;
    logic   gnt_cyc;
    logic   gnt_stb;
    logic   owned;
    logic   route_m1;

    // Lone requester wins; on a tie the master that did not win last time goes.
    always_comb begin
        grant_sel_d = wbm1_cyc_i;
        if (wbm0_cyc_i && wbm1_cyc_i) begin
            grant_sel_d = ~last_sel_q;
        end
    end

    assign gnt_cyc = grant_sel_q ? wbm1_cyc_i : wbm0_cyc_i;
    assign gnt_stb = grant_sel_q ? wbm1_stb_i : wbm0_stb_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_sel_q <= 1'b0;
            last_sel_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wbm0_cyc_i || wbm1_cyc_i) begin
                        state_q     <= OWNED;
                        grant_sel_q <= grant_sel_d;
                        last_sel_q  <= grant_sel_d;
                    end
                end
                OWNED: begin
                    if (!gnt_cyc) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    // Gating with rst kills the slave cycle and acks without waiting for an edge.
    assign owned    = (state_q == OWNED) && !rst;
    assign route_m1 = owned && grant_sel_q;

    always_comb begin
        wbs_adr_o = wbm0_adr_i;
        wbs_dat_o = wbm0_dat_i;
        wbs_we_o  = wbm0_we_i;
        wbs_sel_o = wbm0_sel_i;
        if (route_m1) begin
            wbs_adr_o = wbm1_adr_i;
            wbs_dat_o = wbm1_dat_i;
            wbs_we_o  = wbm1_we_i;
            wbs_sel_o = wbm1_sel_i;
        end
    end

    assign wbs_cyc_o  = owned && gnt_cyc;
    assign wbs_stb_o  = owned && gnt_cyc && gnt_stb;
    // Cyc qualification drops a late slave ack once the owner has let go.
    assign wbm0_ack_o = owned && !grant_sel_q && wbs_ack_i && wbm0_cyc_i;
    assign wbm1_ack_o = owned &&  grant_sel_q && wbs_ack_i && wbm1_cyc_i;

    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;

endmodule

// File: tb/tb_wb_arbiter_rr_2.sv
// Bench for wb_arbiter_rr_2: two behavioural masters, a registered-ack RAM slave
// and an ownership-level reference model checked every cycle.
module tb_wb_arbiter_rr_2;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic        m_stb [2];
    logic        m_cyc [2];

    logic [31:0] wbm0_dat_o, wbm1_dat_o;
    logic        wbm0_ack_o, wbm1_ack_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic        wbs_we_o, wbs_stb_o, wbs_cyc_o;
    logic [3:0]  wbs_sel_o;

    logic [31:0] mem [16];
    logic        s_ack;
    logic [31:0] s_rdat;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owns the slave (-1 = nobody) and who won last.
    int owner;
    int last_win;

    // Master behaviour state.
    int   beats   [2];
    int   gap_cfg [2];
    int   gap_cnt [2];
    int   trans   [2];
    logic acked   [2];
    int   ack_cnt [2];
    logic [31:0] rd_val [2];
    int   ack_log [$];

    always #5 clk = ~clk;

    wb_arbiter_rr_2 dut (
        .clk        (clk),
        .rst        (rst),
        .wbm0_adr_i (m_adr[0]),
        .wbm0_dat_i (m_dat[0]),
        .wbm0_dat_o (wbm0_dat_o),
        .wbm0_we_i  (m_we[0]),
        .wbm0_sel_i (m_sel[0]),
        .wbm0_stb_i (m_stb[0]),
        .wbm0_ack_o (wbm0_ack_o),
        .wbm0_cyc_i (m_cyc[0]),
        .wbm1_adr_i (m_adr[1]),
        .wbm1_dat_i (m_dat[1]),
        .wbm1_dat_o (wbm1_dat_o),
        .wbm1_we_i  (m_we[1]),
        .wbm1_sel_i (m_sel[1]),
        .wbm1_stb_i (m_stb[1]),
        .wbm1_ack_o (wbm1_ack_o),
        .wbm1_cyc_i (m_cyc[1]),
        .wbs_adr_o  (wbs_adr_o),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_dat_i  (s_rdat),
        .wbs_we_o   (wbs_we_o),
        .wbs_sel_o  (wbs_sel_o),
        .wbs_stb_o  (wbs_stb_o),
        .wbs_ack_i  (s_ack),
        .wbs_cyc_o  (wbs_cyc_o)
    );

    // RAM slave with one registered ack per access; its reset is synchronous so the
    // arbiter alone must suppress acks while rst is high.
    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 32'h0;
        s_ack  = 1'b0;
        s_rdat = 32'h0;
    end

    always @(posedge clk) begin
        if (rst) begin
            s_ack <= 1'b0;
        end else begin
            s_ack <= wbs_cyc_o && wbs_stb_o && !s_ack;
            if (wbs_cyc_o && wbs_stb_o && !s_ack) begin
                s_rdat <= mem[wbs_adr_o[5:2]];
                if (wbs_we_o) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wbs_sel_o[b]) mem[wbs_adr_o[5:2]][8*b +: 8] <= wbs_dat_o[8*b +: 8];
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner    = -1;
        last_win = 1;
    endtask

    // Ownership rules at a clock edge.
    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else if (owner < 0) begin
            if (m_cyc[0] && m_cyc[1]) owner = 1 - last_win;
            else if (m_cyc[0])        owner = 0;
            else if (m_cyc[1])        owner = 1;
            if (owner >= 0) last_win = owner;
        end else if (!m_cyc[owner]) begin
            owner = -1;
        end
    endtask

    task automatic check_cycle();
        logic own;
        int   g;
        own = !rst && (owner >= 0);
        g   = own ? owner : 0;
        chk("wbs_cyc", 64'(wbs_cyc_o), 64'(own && m_cyc[g]));
        chk("wbs_stb", 64'(wbs_stb_o), 64'(own && m_cyc[g] && m_stb[g]));
        chk("wbs_adr", 64'(wbs_adr_o), 64'(m_adr[g]));
        chk("wbs_dat", 64'(wbs_dat_o), 64'(m_dat[g]));
        chk("wbs_we",  64'(wbs_we_o),  64'(m_we[g]));
        chk("wbs_sel", 64'(wbs_sel_o), 64'(m_sel[g]));
        chk("m0_ack",  64'(wbm0_ack_o), 64'(own && owner == 0 && s_ack && m_cyc[0]));
        chk("m1_ack",  64'(wbm1_ack_o), 64'(own && owner == 1 && s_ack && m_cyc[1]));
        chk("m0_rdat", 64'(wbm0_dat_o), 64'(s_rdat));
        chk("m1_rdat", 64'(wbm1_dat_o), 64'(s_rdat));
        if (wbm0_ack_o) begin ack_cnt[0]++; ack_log.push_back(0); acked[0] = 1'b1; rd_val[0] = wbm0_dat_o; end
        if (wbm1_ack_o) begin ack_cnt[1]++; ack_log.push_back(1); acked[1] = 1'b1; rd_val[1] = wbm1_dat_o; end
    endtask

    function automatic logic [31:0] rand_adr();
        return 32'($urandom_range(0, 15) * 4);
    endfunction

    task automatic start_m(input int i, input int nb, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input int gap);
        m_cyc[i] = 1'b1;  m_stb[i] = 1'b1;  m_we[i] = we;
        m_adr[i] = adr;   m_dat[i] = dat;   m_sel[i] = sel;
        beats[i] = nb;    gap_cfg[i] = gap; gap_cnt[i] = 0;
    endtask

    // Advance each master after the edge that consumed the cycle's ack.
    task automatic master_update();
        for (int i = 0; i < 2; i++) begin
            if (acked[i]) begin
                beats[i]--;
                m_adr[i] = (m_adr[i] + 32'd4) & 32'h3C;
                m_dat[i] = $urandom;
                if (beats[i] <= 0) begin
                    m_cyc[i] = 1'b0;
                    m_stb[i] = 1'b0;
                end else if (gap_cfg[i] > 0) begin
                    m_stb[i]   = 1'b0;
                    gap_cnt[i] = gap_cfg[i];
                end
            end else if (m_cyc[i] && !m_stb[i]) begin
                if (gap_cnt[i] > 0) gap_cnt[i]--;
                if (gap_cnt[i] == 0) m_stb[i] = 1'b1;
            end else if (!m_cyc[i] && trans[i] > 0) begin
                trans[i]--;
                start_m(i, 1, 1'($urandom_range(0, 1)), rand_adr(), $urandom, 4'hF, 0);
            end
            acked[i] = 1'b0;
        end
    endtask

    task automatic tick();
        #1 check_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        master_update();
    endtask

    task automatic run_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((m_cyc[0] || m_cyc[1] || trans[0] > 0 || trans[1] > 0) && n < budget) begin
            tick();
            n++;
        end
        tick();
        chk(tag, 64'(n < budget), 64'(1));
    endtask

    task automatic clear_logs();
        ack_log.delete();
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = '0; m_dat[i] = '0; m_we[i] = 1'b0; m_sel[i] = '0;
            m_stb[i] = 1'b0; m_cyc[i] = 1'b0;
            beats[i] = 0; gap_cfg[i] = 0; gap_cnt[i] = 0; trans[i] = 0;
            acked[i] = 1'b0; ack_cnt[i] = 0; rd_val[i] = '0;
        end
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_cyc", 64'(wbs_cyc_o), 64'(0));
        chk("rst_stb", 64'(wbs_stb_o), 64'(0));
        do_reset();

        // Single write from m0, one-cycle grant latency.
        clear_logs();
        start_m(0, 1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        #1 chk("t1_cyc_same_cycle", 64'(wbs_cyc_o), 64'(0));
        tick();
        #1 chk("t1_cyc_next_cycle", 64'(wbs_cyc_o), 64'(1));
        run_idle("t1_done", 50);
        chk("t1_mem", 64'(mem[4]), 64'(32'hDEADBEEF));
        chk("t1_m0_acks", 64'(ack_cnt[0]), 64'(1));
        chk("t1_m1_acks", 64'(ack_cnt[1]), 64'(0));

        // Simultaneous reads after reset: m0 first, then m1.
        do_reset();
        clear_logs();
        start_m(0, 1, 1'b0, 32'h10, 32'h0, 4'hF, 0);
        start_m(1, 1, 1'b0, 32'h10, 32'h0, 4'hF, 0);
        run_idle("t2_done", 50);
        chk("t2_n", 64'(ack_log.size()), 64'(2));
        chk("t2_first", 64'(ack_log.size() > 0 ? ack_log[0] : -1), 64'(0));
        chk("t2_m1_rdat", 64'(rd_val[1]), 64'(32'hDEADBEEF));

        // Continuous requests from both: strict alternation, four acks each.
        clear_logs();
        trans[0] = 4;
        trans[1] = 4;
        master_update();
        run_idle("t3_done", 200);
        chk("t3_n", 64'(ack_log.size()), 64'(8));
        for (int k = 0; k < 8; k++) chk($sformatf("t3_order%0d", k), 64'(ack_log.size() > k ? ack_log[k] : -1), 64'(k % 2));
        chk("t3_m0_acks", 64'(ack_cnt[0]), 64'(4));
        chk("t3_m1_acks", 64'(ack_cnt[1]), 64'(4));

        // m1 burst with stb gaps is never interleaved with m0.
        clear_logs();
        start_m(1, 4, 1'b1, 32'h20, 32'h11112222, 4'hF, 2);
        tick();
        start_m(0, 1, 1'b0, 32'h20, 32'h0, 4'hF, 0);
        run_idle("t4_done", 200);
        chk("t4_n", 64'(ack_log.size()), 64'(5));
        for (int k = 0; k < 5; k++) chk($sformatf("t4_order%0d", k), 64'(ack_log.size() > k ? ack_log[k] : -1), 64'(k < 4 ? 1 : 0));

        // Asynchronous reset while m0's ack is on the slave bus.
        clear_logs();
        start_m(0, 1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0);
        tick();
        tick();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_cyc", 64'(wbs_cyc_o), 64'(0));
        chk("t5_stb", 64'(wbs_stb_o), 64'(0));
        chk("t5_ack0", 64'(wbm0_ack_o), 64'(0));
        chk("t5_ack1", 64'(wbm1_ack_o), 64'(0));
        start_m(1, 1, 1'b0, 32'h30, 32'h0, 4'hF, 0);
        tick();
        tick();
        rst = 1'b0;
        run_idle("t5_done", 50);
        chk("t5_first", 64'(ack_log.size() > 0 ? ack_log[0] : -1), 64'(0));
        chk("t5_m0_acks", 64'(ack_cnt[0]), 64'(1));

        // m0 drops cyc in the very cycle the slave acks.
        clear_logs();
        start_m(0, 1, 1'b0, 32'h04, 32'h0, 4'hF, 0);
        tick();
        tick();
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        beats[0] = 0;
        #1 chk("t6_late_ack", 64'(wbm0_ack_o), 64'(0));
        tick();
        start_m(1, 1, 1'b0, 32'h08, 32'h0, 4'hF, 0);
        tick();
        #1 chk("t6_m1_granted", 64'(wbs_cyc_o), 64'(1));
        run_idle("t6_done", 50);
        chk("t6_m0_acks", 64'(ack_cnt[0]), 64'(0));

        // Randomized traffic against the ownership model.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_cyc[i] && trans[i] == 0 && $urandom_range(0, 3) == 0) begin
                    start_m(i, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), rand_adr(),
                            $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
                end
            end
            tick();
        end
        run_idle("rand_done", 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
